// File: rtl/mips_ctrl_pkg.sv
// Opcodes, state encoding and the control bundle shared by the
// multi-cycle MIPS main control FSM and its helpers.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_RT     = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        MEM_ADDR  = 4'd2,
        MEM_READ  = 4'd3,
        MEM_WB    = 4'd4,
        MEM_WRITE = 4'd5,
        EXECUTE   = 4'd6,
        RTYPE_WB  = 4'd7,
        BRANCH    = 4'd8,
        JUMP      = 4'd9,
        ADDI_EXEC = 4'd10,
        ADDI_WB   = 4'd11
    } state_t;

    typedef struct packed {
        logic       pcWrite;
        logic       pcWriteCond;
        logic [1:0] pcSource;
        logic       iorD;
        logic       memRead;
        logic       memWrite;
        logic       irWrite;
        logic       regDst;
        logic       memToReg;
        logic       regWrite;
        logic       aluSrcA;
        logic [1:0] aluSrcB;
        logic [1:0] aluInstruct;
        logic       instrDone;
        logic       illegalOp;
        logic       memError;
    } ctrl_t;

    function automatic logic is_wait_state(state_t s);
        return s inside {FETCH, MEM_READ, MEM_WRITE};
    endfunction

endpackage

// File: rtl/mips_mem_wait_timer.sv
// Counts consecutive not-ready cycles in a memory wait state and flags
// expiry on the last allowed cycle; MEM_TIMEOUT=0 disables expiry.
module mips_mem_wait_timer #(
    parameter int MEM_TIMEOUT = 255,
    parameter int TIMEOUT_W   = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic active,
    input  logic memReady,
    output logic expired
);

    localparam logic [TIMEOUT_W-1:0] LAST =
        TIMEOUT_W'(MEM_TIMEOUT > 0 ? MEM_TIMEOUT - 1 : 0);

    logic [TIMEOUT_W-1:0] wait_cnt;

    assign expired = (MEM_TIMEOUT != 0) && active && !memReady
                     && (wait_cnt == LAST);

    // Held at zero outside wait states, so entering one starts from zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            wait_cnt <= '0;
        else if (!active || memReady || expired)
            wait_cnt <= '0;
        else if (wait_cnt != '1)
            wait_cnt <= wait_cnt + TIMEOUT_W'(1);
    end

endmodule

// File: rtl/mips_main_control_fsm.sv
// Multi-cycle MIPS main control: sequences fetch/decode/execute/mem/wb
// and drives datapath enables plus the ALUOp field for ALU control.
module mips_main_control_fsm #(
    parameter int MEM_TIMEOUT = 255,
    parameter int TIMEOUT_W   = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       memReady,
    output logic       pcWrite,
    output logic       pcWriteCond,
    output logic [1:0] pcSource,
    output logic       iorD,
    output logic       memRead,
    output logic       memWrite,
    output logic       irWrite,
    output logic       regDst,
    output logic       memToReg,
    output logic       regWrite,
    output logic       aluSrcA,
    output logic [1:0] aluSrcB,
    output logic [1:0] aluInstruct,
    output logic       instrDone,
    output logic       illegalOp,
    output logic       memError
);

    import mips_ctrl_pkg::*;

    state_t state, next;
    ctrl_t  c, ctrl;
    logic   expired;

    mips_mem_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT),
        .TIMEOUT_W  (TIMEOUT_W)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .active  (is_wait_state(state)),
        .memReady(memReady),
        .expired (expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= FETCH;
        else
            state <= next;
    end

    always_comb begin
        next = state;
        c    = '0;
        unique case (state)
            FETCH: begin
                c.memRead     = 1'b1;
                c.aluSrcB     = SRCB_FOUR;
                c.aluInstruct = ALUOP_ADD;
                c.irWrite     = memReady;
                c.pcWrite     = memReady;
                if (memReady)
                    next = DECODE;
            end
            DECODE: begin
                c.aluSrcB     = SRCB_IMM_SH;
                c.aluInstruct = ALUOP_ADD;
                case (opcode)
                    OP_RTYPE:     next = EXECUTE;
                    OP_LW, OP_SW: next = MEM_ADDR;
                    OP_BEQ:       next = BRANCH;
                    OP_J:         next = JUMP;
                    OP_ADDI:      next = ADDI_EXEC;
                    default: begin
                        c.illegalOp = 1'b1;
                        next        = FETCH;
                    end
                endcase
            end
            MEM_ADDR: begin
                c.aluSrcA     = 1'b1;
                c.aluSrcB     = SRCB_IMM;
                c.aluInstruct = ALUOP_ADD;
                next = (opcode == OP_SW) ? MEM_WRITE : MEM_READ;
            end
            MEM_READ: begin
                c.memRead = 1'b1;
                c.iorD    = 1'b1;
                if (memReady)
                    next = MEM_WB;
                else if (expired)
                    next = FETCH;
            end
            MEM_WB: begin
                c.memToReg  = 1'b1;
                c.regWrite  = 1'b1;
                c.instrDone = 1'b1;
                next = FETCH;
            end
            MEM_WRITE: begin
                c.memWrite  = 1'b1;
                c.iorD      = 1'b1;
                c.instrDone = memReady;
                if (memReady || expired)
                    next = FETCH;
            end
            EXECUTE: begin
                c.aluSrcA     = 1'b1;
                c.aluSrcB     = SRCB_RT;
                c.aluInstruct = ALUOP_FUNCT;
                next = RTYPE_WB;
            end
            RTYPE_WB: begin
                c.regDst    = 1'b1;
                c.regWrite  = 1'b1;
                c.instrDone = 1'b1;
                next = FETCH;
            end
            BRANCH: begin
                c.aluSrcA     = 1'b1;
                c.aluInstruct = ALUOP_SUB;
                c.pcWriteCond = 1'b1;
                c.pcSource    = PCSRC_ALUOUT;
                c.instrDone   = 1'b1;
                next = FETCH;
            end
            JUMP: begin
                c.pcWrite   = 1'b1;
                c.pcSource  = PCSRC_JUMP;
                c.instrDone = 1'b1;
                next = FETCH;
            end
            ADDI_EXEC: begin
                c.aluSrcA     = 1'b1;
                c.aluSrcB     = SRCB_IMM;
                c.aluInstruct = ALUOP_ADD;
                next = ADDI_WB;
            end
            ADDI_WB: begin
                c.regWrite  = 1'b1;
                c.instrDone = 1'b1;
                next = FETCH;
            end
            default: next = FETCH;
        endcase
        c.memError = expired;
    end

    // Reset must silence the Moore outputs of FETCH immediately.
    assign ctrl = reset ? '0 : c;

    assign pcWrite     = ctrl.pcWrite;
    assign pcWriteCond = ctrl.pcWriteCond;
    assign pcSource    = ctrl.pcSource;
    assign iorD        = ctrl.iorD;
    assign memRead     = ctrl.memRead;
    assign memWrite    = ctrl.memWrite;
    assign irWrite     = ctrl.irWrite;
    assign regDst      = ctrl.regDst;
    assign memToReg    = ctrl.memToReg;
    assign regWrite    = ctrl.regWrite;
    assign aluSrcA     = ctrl.aluSrcA;
    assign aluSrcB     = ctrl.aluSrcB;
    assign aluInstruct = ctrl.aluInstruct;
    assign instrDone   = ctrl.instrDone;
    assign illegalOp   = ctrl.illegalOp;
    assign memError    = ctrl.memError;

endmodule

// File: tb/tb_mips_main_control_fsm.sv
// Random instruction stream with per-instruction memory stalls, checked
// cycle by cycle against an instruction-level expected-trace model.
module tb_mips_main_control_fsm;

    localparam int TMO = 4;

    localparam logic [5:0] R_OP    = 6'b000000;
    localparam logic [5:0] LW_OP   = 6'b100011;
    localparam logic [5:0] SW_OP   = 6'b101011;
    localparam logic [5:0] BEQ_OP  = 6'b000100;
    localparam logic [5:0] J_OP    = 6'b000010;
    localparam logic [5:0] ADDI_OP = 6'b001000;

    typedef struct packed {
        logic       pcWrite;
        logic       pcWriteCond;
        logic [1:0] pcSource;
        logic       iorD;
        logic       memRead;
        logic       memWrite;
        logic       irWrite;
        logic       regDst;
        logic       memToReg;
        logic       regWrite;
        logic       aluSrcA;
        logic [1:0] aluSrcB;
        logic [1:0] aluInstruct;
        logic       instrDone;
        logic       illegalOp;
        logic       memError;
    } outs_t;

    typedef struct packed {
        logic       mr;
        logic [5:0] op;
        outs_t      exp;
    } ent_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic       memReady;
    logic       pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite;
    logic       regDst, memToReg, regWrite, aluSrcA;
    logic       instrDone, illegalOp, memError;
    logic [1:0] pcSource, aluSrcB, aluInstruct;
    outs_t      act;

    int checks = 0;
    int errors = 0;
    int n_instr = 0;

    ent_t        q[$];
    string       tq[$];
    logic [5:0]  cur_op;
    logic [5:0]  legal_ops [6];

    always #5 clk = ~clk;

    mips_main_control_fsm #(
        .MEM_TIMEOUT(TMO),
        .TIMEOUT_W  (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .memReady   (memReady),
        .pcWrite    (pcWrite),
        .pcWriteCond(pcWriteCond),
        .pcSource   (pcSource),
        .iorD       (iorD),
        .memRead    (memRead),
        .memWrite   (memWrite),
        .irWrite    (irWrite),
        .regDst     (regDst),
        .memToReg   (memToReg),
        .regWrite   (regWrite),
        .aluSrcA    (aluSrcA),
        .aluSrcB    (aluSrcB),
        .aluInstruct(aluInstruct),
        .instrDone  (instrDone),
        .illegalOp  (illegalOp),
        .memError   (memError)
    );

    assign act = {pcWrite, pcWriteCond, pcSource, iorD, memRead, memWrite,
                  irWrite, regDst, memToReg, regWrite, aluSrcA, aluSrcB,
                  aluInstruct, instrDone, illegalOp, memError};

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic is_legal(input logic [5:0] op);
        return op inside {R_OP, LW_OP, SW_OP, BEQ_OP, J_OP, ADDI_OP};
    endfunction

    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic push(input logic mr, input outs_t e, input string tag);
        q.push_back({mr, cur_op, e});
        tq.push_back($sformatf("%s#%0d", tag, n_instr));
    endtask

    function automatic outs_t fetch_out();
        outs_t e = '0;
        e.memRead = 1'b1;
        e.aluSrcB = 2'b01;
        return e;
    endfunction

    // Memory phase of lw/sw: m not-ready cycles, watchdog may abort it.
    task automatic add_mem(input logic is_sw, input int m);
        outs_t e;
        for (int i = 0; i < m && i < TMO; i++) begin
            e = '0;
            e.iorD = 1'b1;
            if (is_sw) e.memWrite = 1'b1;
            else       e.memRead  = 1'b1;
            if (i == TMO - 1) e.memError = 1'b1;
            push(1'b0, e, "mem_stall");
        end
        if (m >= TMO) return;
        e = '0;
        e.iorD = 1'b1;
        if (is_sw) begin
            e.memWrite  = 1'b1;
            e.instrDone = 1'b1;
        end else begin
            e.memRead = 1'b1;
        end
        push(1'b1, e, "mem_done");
        if (!is_sw) begin
            e = '0;
            e.memToReg  = 1'b1;
            e.regWrite  = 1'b1;
            e.instrDone = 1'b1;
            push(rnd(), e, "lw_wb");
        end
    endtask

    task automatic add_instr(input logic [5:0] op, input int fst,
                             input int mst);
        outs_t e;
        int w = 0;
        n_instr++;
        cur_op = op;
        for (int i = 0; i < fst; i++) begin
            e = fetch_out();
            w++;
            if (w == TMO) begin
                e.memError = 1'b1;
                w = 0;
            end
            push(1'b0, e, "fetch_stall");
        end
        e = fetch_out();
        e.irWrite = 1'b1;
        e.pcWrite = 1'b1;
        push(1'b1, e, "fetch");
        e = '0;
        e.aluSrcB = 2'b11;
        if (!is_legal(op)) begin
            e.illegalOp = 1'b1;
            push(rnd(), e, "decode_illegal");
            return;
        end
        push(rnd(), e, "decode");
        e = '0;
        case (op)
            R_OP: begin
                e.aluSrcA     = 1'b1;
                e.aluInstruct = 2'b10;
                push(rnd(), e, "r_exec");
                e = '0;
                e.regDst    = 1'b1;
                e.regWrite  = 1'b1;
                e.instrDone = 1'b1;
                push(rnd(), e, "r_wb");
            end
            ADDI_OP: begin
                e.aluSrcA = 1'b1;
                e.aluSrcB = 2'b10;
                push(rnd(), e, "addi_exec");
                e = '0;
                e.regWrite  = 1'b1;
                e.instrDone = 1'b1;
                push(rnd(), e, "addi_wb");
            end
            BEQ_OP: begin
                e.aluSrcA     = 1'b1;
                e.aluInstruct = 2'b01;
                e.pcWriteCond = 1'b1;
                e.pcSource    = 2'b01;
                e.instrDone   = 1'b1;
                push(rnd(), e, "beq");
            end
            J_OP: begin
                e.pcWrite   = 1'b1;
                e.pcSource  = 2'b10;
                e.instrDone = 1'b1;
                push(rnd(), e, "jump");
            end
            default: begin
                e.aluSrcA = 1'b1;
                e.aluSrcB = 2'b10;
                push(rnd(), e, "mem_addr");
                add_mem(op == SW_OP, mst);
            end
        endcase
    endtask

    // Entered at posedge+1; leaves at posedge+1 after each entry.
    task automatic run_n(input int n);
        ent_t  en;
        string tg;
        for (int i = 0; i < n && q.size() > 0; i++) begin
            en = q.pop_front();
            tg = tq.pop_front();
            memReady = en.mr;
            opcode   = en.op;
            @(negedge clk);
            check(tg, 32'(act), 32'(en.exp));
            check("inv_rd_wr", 32'(memRead & memWrite), 32'd0);
            check("inv_rw_ir", 32'(regWrite & irWrite), 32'd0);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_all();
        run_n(q.size());
    endtask

    initial begin
        logic [5:0] op;
        int         sel;
        int         fst;
        legal_ops = '{R_OP, LW_OP, SW_OP, BEQ_OP, J_OP, ADDI_OP};
        reset    = 1'b1;
        memReady = 1'b1;
        opcode   = R_OP;
        repeat (2) @(negedge clk);
        check("reset_outs", 32'(act), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        add_instr(R_OP, 0, 0);
        add_instr(LW_OP, 0, 3);
        add_instr(BEQ_OP, 0, 0);
        add_instr(6'b111111, 0, 0);
        add_instr(SW_OP, 0, 6);
        add_instr(ADDI_OP, 5, 0);
        add_instr(LW_OP, 1, 4);
        run_all();

        for (int k = 0; k < 80; k++) begin
            sel = $urandom_range(0, 7);
            if (sel < 6) begin
                op = legal_ops[sel];
            end else begin
                op = 6'($urandom);
                while (is_legal(op)) op = 6'($urandom);
            end
            fst = ($urandom_range(0, 9) == 0) ? $urandom_range(4, 6)
                                              : $urandom_range(0, 2);
            add_instr(op, fst, $urandom_range(0, 5));
            run_all();
        end

        add_instr(R_OP, 0, 0);
        run_n(2);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("reset_in_exec", 32'(act), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        q.delete();
        tq.delete();
        add_instr(J_OP, 1, 0);
        run_all();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
